// File: rtl/ysyx_22050854_divider_v1.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Define DIV_FAST_PATH_EN to finish divide-by-zero, overflow and |a|<|b| ops straight from IDLE.
module ysyx_22050854_divider_v1 #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            div_valid,
  input  logic            divw,
  input  logic            div_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            div_ready,
  output logic            div_doing,
  output logic            out_valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_W = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST_D = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] a_orig_q;
  logic            neg_q_q;
  logic            neg_r_q;
  logic            zero_q;
  logic            ovf_q;
  logic            w_q;
  logic            valid_q;
  logic [XLEN-1:0] q_out;
  logic [XLEN-1:0] r_out;

  function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] v);
    return {{HALF{v[HALF-1]}}, v};
  endfunction

  // Sign fix, RISC-V special-case override, then W-form sign extension of both results.
  function automatic logic [2*XLEN-1:0] finalize(
    input logic [XLEN-1:0] q_mag,
    input logic [XLEN-1:0] r_mag,
    input logic            neg_q,
    input logic            neg_r,
    input logic            w,
    input logic            zero,
    input logic            ovf,
    input logic [XLEN-1:0] a_orig
  );
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    q = neg_q ? -q_mag : q_mag;
    r = neg_r ? -r_mag : r_mag;
    if (zero) begin
      q = '1;
      r = a_orig;
    end else if (ovf) begin
      q = a_orig;
      r = '0;
    end
    if (w) begin
      q = sext_half(q[HALF-1:0]);
      r = sext_half(r[HALF-1:0]);
    end
    return {q, r};
  endfunction

  logic [XLEN-1:0] a_eff;
  logic [XLEN-1:0] b_eff;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] a_init;
  logic [XLEN-1:0] min_eff;
  logic            a_neg;
  logic            b_neg;
  logic            b_zero;
  logic            ovf;
  logic            accept;

  assign a_eff   = divw ? (div_signed ? sext_half(dividend[HALF-1:0])
                                      : {{HALF{1'b0}}, dividend[HALF-1:0]})
                        : dividend;
  assign b_eff   = divw ? (div_signed ? sext_half(divisor[HALF-1:0])
                                      : {{HALF{1'b0}}, divisor[HALF-1:0]})
                        : divisor;
  assign a_neg   = div_signed & a_eff[XLEN-1];
  assign b_neg   = div_signed & b_eff[XLEN-1];
  assign a_abs   = a_neg ? -a_eff : a_eff;
  assign b_abs   = b_neg ? -b_eff : b_eff;
  // W-form magnitudes start in the top half so the iteration always consumes a_q's MSB.
  assign a_init  = divw ? {a_abs[HALF-1:0], {HALF{1'b0}}} : a_abs;
  assign min_eff = divw ? sext_half({1'b1, {(HALF-1){1'b0}}}) : {1'b1, {(XLEN-1){1'b0}}};
  assign b_zero  = (b_eff == '0);
  assign ovf     = div_signed & (&b_eff) & (a_eff == min_eff);
  assign accept  = div_valid & div_ready & ~flush;

`ifdef DIV_FAST_PATH_EN
  logic a_lt_b;
  assign a_lt_b = (a_abs < b_abs);
`endif

  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] a_next;

  assign rem_shift = {rem_q, a_q[XLEN-1]};
  assign diff      = rem_shift - {1'b0, b_q};
  assign ge        = ~diff[XLEN];
  assign rem_next  = ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign a_next    = {a_q[XLEN-2:0], ge};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      a_q       <= '0;
      rem_q     <= '0;
      b_q       <= '0;
      a_orig_q  <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      w_q       <= 1'b0;
      valid_q   <= 1'b0;
      q_out     <= '0;
      r_out     <= '0;
      div_ready <= 1'b1;
      div_doing <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      q_out   <= '0;
      r_out   <= '0;
      if (flush && state != IDLE) begin
        state     <= IDLE;
        count     <= '0;
        a_q       <= '0;
        rem_q     <= '0;
        b_q       <= '0;
        div_ready <= 1'b1;
        div_doing <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              a_q       <= a_init;
              rem_q     <= '0;
              b_q       <= b_abs;
              a_orig_q  <= a_eff;
              neg_q_q   <= a_neg ^ b_neg;
              neg_r_q   <= a_neg;
              zero_q    <= b_zero;
              ovf_q     <= ovf;
              w_q       <= divw;
              count     <= '0;
              div_ready <= 1'b0;
              div_doing <= 1'b1;
`ifdef DIV_FAST_PATH_EN
              if (b_zero || ovf || a_lt_b) begin
                state          <= DONE;
                valid_q        <= 1'b1;
                {q_out, r_out} <= finalize('0, a_abs, a_neg ^ b_neg, a_neg, divw,
                                           b_zero, ovf, a_eff);
              end else begin
                state <= CALC;
              end
`else
              state <= CALC;
`endif
            end
          end
          CALC: begin
            a_q   <= a_next;
            rem_q <= rem_next;
            count <= count + 1'b1;
            if (count == (w_q ? LAST_W : LAST_D)) begin
              state          <= DONE;
              valid_q        <= 1'b1;
              {q_out, r_out} <= finalize(a_next, rem_next, neg_q_q, neg_r_q, w_q,
                                         zero_q, ovf_q, a_orig_q);
            end
          end
          DONE: begin
            state     <= IDLE;
            count     <= '0;
            a_q       <= '0;
            rem_q     <= '0;
            b_q       <= '0;
            div_ready <= 1'b1;
            div_doing <= 1'b0;
          end
          default: begin
            state     <= IDLE;
            div_ready <= 1'b1;
            div_doing <= 1'b0;
          end
        endcase
      end
    end
  end

  // A flush landing in the DONE cycle suppresses the result in that same cycle.
  assign out_valid = valid_q & ~flush;
  assign quotient  = out_valid ? q_out : '0;
  assign remainder = out_valid ? r_out : '0;

endmodule

// File: tb/tb_ysyx_22050854_divider_v1.sv
// Self-checking bench for ysyx_22050854_divider_v1: directed corner cases plus random ops
// compared against an arithmetic reference model; honours DIV_FAST_PATH_EN timing.
module tb_ysyx_22050854_divider_v1;

  logic        clock;
  logic        reset;
  logic        div_valid;
  logic        divw;
  logic        div_signed;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        flush;
  logic        div_ready;
  logic        div_doing;
  logic        out_valid;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int vectors;
  int miscompares;

  ysyx_22050854_divider_v1 #(.XLEN(64)) dut (
    .clock      (clock),
    .reset      (reset),
    .div_valid  (div_valid),
    .divw       (divw),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .flush      (flush),
    .div_ready  (div_ready),
    .div_doing  (div_doing),
    .out_valid  (out_valid),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      $error("[TB] check %s miscompared", tag);
    end
  endtask

  // RISC-V division semantics computed with native arithmetic.
  task automatic ref_model(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] q, output logic [63:0] r, output int lat);
    logic [63:0]        ea;
    logic [63:0]        eb;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic               ovf;
    ea  = w ? (s ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
    eb  = w ? (s ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
    ovf = s && (eb == 64'hFFFF_FFFF_FFFF_FFFF) &&
          (ea == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    if (eb == 64'd0) begin
      q = 64'hFFFF_FFFF_FFFF_FFFF;
      r = ea;
    end else if (ovf) begin
      q = ea;
      r = 64'd0;
    end else if (s) begin
      sa = ea;
      sb = eb;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = ea / eb;
      r = ea % eb;
    end
    if (w) begin
      q = {{32{q[31]}}, q[31:0]};
      r = {{32{r[31]}}, r[31:0]};
    end
`ifdef DIV_FAST_PATH_EN
    begin
      logic [63:0] ma;
      logic [63:0] mb;
      ma  = (s && ea[63]) ? 64'd0 - ea : ea;
      mb  = (s && eb[63]) ? 64'd0 - eb : eb;
      lat = ((eb == 64'd0) || ovf || (ma < mb)) ? 1 : (w ? 33 : 65);
    end
`else
    lat = w ? 33 : 65;
`endif
  endtask

  // Presents one op for a single cycle; returns in cycle 1 after the accept edge.
  task automatic apply_stimulus(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b);
    divw       = w;
    div_signed = s;
    dividend   = a;
    divisor    = b;
    div_valid  = 1'b1;
    @(posedge clock); #1;
    div_valid  = 1'b0;
  endtask

  // Called in cycle 1; waits (bounded) for out_valid, then checks timing, results and recovery.
  task automatic wait_result(input string tag, input int lat, input logic [63:0] eq, input logic [63:0] er);
    int   cyc;
    logic seen;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 200) begin
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clock); #1;
        cyc++;
      end
    end
    check_output({tag, "_latency"}, seen ? 64'(cyc) : 64'd0, 64'(lat));
    if (seen) begin
      check_output({tag, "_quotient"}, quotient, eq);
      check_output({tag, "_remainder"}, remainder, er);
      @(posedge clock); #1;
      check_output({tag, "_ready_after"}, 64'(div_ready), 64'd1);
      check_output({tag, "_valid_pulse"}, 64'(out_valid), 64'd0);
      check_output({tag, "_q_zeroed"}, quotient, 64'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic w, input logic s, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] eq;
    logic [63:0] er;
    int          lat;
    ref_model(w, s, a, b, eq, er, lat);
    check_output({tag, "_ready_before"}, 64'(div_ready), 64'd1);
    apply_stimulus(w, s, a, b);
    wait_result(tag, lat, eq, er);
  endtask

  logic [63:0] rand_a;
  logic [63:0] rand_b;
  logic        rand_w;
  logic        rand_s;
  logic [63:0] exp_q;
  logic [63:0] exp_r;
  int          exp_lat;
  int          stray;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    div_valid   = 1'b0;
    divw        = 1'b0;
    div_signed  = 1'b0;
    dividend    = 64'd0;
    divisor     = 64'd0;
    flush       = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_output("reset_ready", 64'(div_ready), 64'd1);
    check_output("reset_doing", 64'(div_doing), 64'd0);
    check_output("reset_valid", 64'(out_valid), 64'd0);
    check_output("reset_quotient", quotient, 64'd0);
    check_output("reset_remainder", remainder, 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    $display("[TB] directed corner cases");
    run_op("s64_m7_by_2", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    run_op("divuw_min_by_1", 1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'd1);
    run_op("s64_100_by_0", 1'b0, 1'b1, 64'd100, 64'd0);
    run_op("s64_overflow", 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("w_overflow", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
    run_op("u64_small_by_big", 1'b0, 1'b0, 64'd5, 64'd1000);
    run_op("divuw_by_0", 1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000);

    $display("[TB] flush mid-calc");
    apply_stimulus(1'b0, 1'b1, 64'd1000, 64'd3);
    repeat (19) begin
      @(posedge clock); #1;
    end
    flush = 1'b1;
    #1;
    check_output("flush_calc_valid", 64'(out_valid), 64'd0);
    check_output("flush_calc_doing", 64'(div_doing), 64'd1);
    @(posedge clock); #1;
    flush = 1'b0;
    check_output("flush_calc_ready", 64'(div_ready), 64'd1);
    check_output("flush_calc_idle", 64'(div_doing), 64'd0);
    run_op("after_flush_9_by_4", 1'b0, 1'b1, 64'd9, 64'd4);

    $display("[TB] flush in the result cycle");
    ref_model(1'b0, 1'b0, 64'd50, 64'd7, exp_q, exp_r, exp_lat);
    apply_stimulus(1'b0, 1'b0, 64'd50, 64'd7);
    repeat (exp_lat - 1) begin
      @(posedge clock); #1;
    end
    check_output("flush_done_pre_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    #1;
    check_output("flush_done_valid", 64'(out_valid), 64'd0);
    check_output("flush_done_quotient", quotient, 64'd0);
    @(posedge clock); #1;
    flush = 1'b0;
    check_output("flush_done_ready", 64'(div_ready), 64'd1);
    check_output("flush_done_after", 64'(out_valid), 64'd0);

    $display("[TB] flush together with accept");
    divw       = 1'b0;
    div_signed = 1'b0;
    dividend   = 64'd77;
    divisor    = 64'd0;
    div_valid  = 1'b1;
    flush      = 1'b1;
    @(posedge clock); #1;
    div_valid = 1'b0;
    flush     = 1'b0;
    check_output("flush_accept_ready", 64'(div_ready), 64'd1);
    check_output("flush_accept_doing", 64'(div_doing), 64'd0);
    stray = 0;
    repeat (70) begin
      @(posedge clock); #1;
      if (out_valid || div_doing) stray++;
    end
    check_output("flush_accept_dropped", 64'(stray), 64'd0);

    $display("[TB] back-to-back with div_valid held");
    ref_model(1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'd1, exp_q, exp_r, exp_lat);
    divw       = 1'b1;
    div_signed = 1'b0;
    dividend   = 64'h0000_0000_8000_0000;
    divisor    = 64'd1;
    div_valid  = 1'b1;
    @(posedge clock); #1;
    div_signed = 1'b1;
    dividend   = 64'd5;
    divisor    = 64'd0;
    check_output("b2b_busy_ready", 64'(div_ready), 64'd0);
    wait_result("b2b_op1", exp_lat, exp_q, exp_r);
    check_output("b2b_gap_doing", 64'(div_doing), 64'd0);
    ref_model(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, exp_q, exp_r, exp_lat);
    divw       = 1'b0;
    div_signed = 1'b1;
    dividend   = 64'hFFFF_FFFF_FFFF_FFF9;
    divisor    = 64'd2;
    @(posedge clock); #1;
    div_valid = 1'b0;
    check_output("b2b_op2_doing", 64'(div_doing), 64'd1);
    check_output("b2b_op2_ready", 64'(div_ready), 64'd0);
    wait_result("b2b_op2", exp_lat, exp_q, exp_r);

    $display("[TB] random ops");
    for (int i = 0; i < 24; i++) begin
      rand_w = 1'($urandom_range(0, 1));
      rand_s = 1'($urandom_range(0, 1));
      rand_a = {$urandom(), $urandom()};
      case ($urandom_range(0, 5))
        0:       rand_b = rand_w ? {$urandom(), 32'd0} : 64'd0;
        1:       rand_b = rand_w ? {$urandom(), 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        2:       rand_b = 64'($urandom_range(1, 100));
        3:       rand_b = {$urandom(), $urandom()};
        4:       rand_b = {$urandom(), $urandom()} >> $urandom_range(1, 62);
        default: rand_b = 64'($urandom());
      endcase
      if ($urandom_range(0, 4) == 0)
        rand_a = rand_w ? {rand_a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
      run_op($sformatf("rand%0d", i), rand_w, rand_s, rand_a, rand_b);
    end

    $display("[TB] reset pulsed mid-calc");
    apply_stimulus(1'b0, 1'b0, 64'd1000, 64'd3);
    repeat (9) begin
      @(posedge clock); #1;
    end
    reset = 1'b0;
    #1;
    check_output("midreset_ready", 64'(div_ready), 64'd1);
    check_output("midreset_doing", 64'(div_doing), 64'd0);
    check_output("midreset_valid", 64'(out_valid), 64'd0);
    check_output("midreset_quotient", quotient, 64'd0);
    check_output("midreset_remainder", remainder, 64'd0);
    #2;
    reset = 1'b1;
    stray = 0;
    repeat (80) begin
      @(posedge clock); #1;
      if (out_valid) stray++;
    end
    check_output("midreset_no_stale", 64'(stray), 64'd0);
    run_op("after_reset_9_by_4", 1'b0, 1'b0, 64'd9, 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
